// File: rtl/spi_master_engine_if.sv
// Command, status and pre-polarity pin bundle between a
// command source (master) and spi_master_engine (slave).
interface spi_master_engine_if #(
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 7,
  parameter int DIV_WIDTH  = 8,
  parameter int NUM_CS     = 1
);
  logic                  start;
  logic [DATA_WIDTH-1:0] data_in;
  logic [LEN_WIDTH-1:0]  length;
  logic [DIV_WIDTH-1:0]  clk_div;
  logic                  cpha;
  logic                  lsb_first;
  logic [NUM_CS-1:0]     cs_sel;
  logic [LEN_WIDTH-1:0]  readback_start;
  logic                  sdi_in;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  sdo;
  logic                  sck_next;
  logic                  cs_next;
  logic                  slave_en;
  logic [NUM_CS-1:0]     cs_val;

  modport master (
    output start, data_in, length, clk_div,
    output cpha, lsb_first, cs_sel,
    output readback_start, sdi_in,
    input  busy, done, data_out, sdo,
    input  sck_next, cs_next, slave_en, cs_val
  );

  modport slave (
    input  start, data_in, length, clk_div,
    input  cpha, lsb_first, cs_sel,
    input  readback_start, sdi_in,
    output busy, done, data_out, sdo,
    output sck_next, cs_next, slave_en, cs_val
  );
endinterface

// File: rtl/spi_master_engine.sv
// Bit-level SPI sequencer ahead of the output stage.
// Define SPI_READBACK_EN to enable the tristate readback path.
module spi_master_engine #(
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 7,
  parameter int DIV_WIDTH  = 8,
  parameter int NUM_CS     = 1
) (
  input  logic                CLK100MHZ,
  input  logic                reset,
  spi_master_engine_if.slave  bus
);

  localparam logic [LEN_WIDTH-1:0] DW_L = LEN_WIDTH'(DATA_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP, S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [LEN_WIDTH-1:0]  bit_q, bit_d;
  logic                  ph_q, ph_d;

  logic [DATA_WIDTH-1:0] data_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [DIV_WIDTH-1:0]  cdiv_q;
  logic                  cpha_q;
  logic                  lsb_q;
  logic [NUM_CS-1:0]     cs_val_q, cs_val_d;

  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  sdo_q, sdo_d;
  logic                  sck_q, sck_d;
  logic                  cs_q, cs_d;

  logic                  accept;
  logic                  div_last;
  logic [LEN_WIDTH-1:0]  len_in;

  assign accept   = (state_q == S_IDLE) && bus.start
                    && (bus.length != '0);
  assign len_in   = (bus.length > DW_L) ? DW_L : bus.length;
  assign div_last = (div_q == cdiv_q);

  function automatic logic pick(
    input logic [DATA_WIDTH-1:0] d,
    input logic [LEN_WIDTH-1:0]  l,
    input logic                  lsb,
    input logic [LEN_WIDTH-1:0]  i
  );
    logic [DATA_WIDTH-1:0] sh;
    sh = lsb ? (d >> i) : (d >> (l - 1'b1 - i));
    return sh[0];
  endfunction

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      ph_q     <= 1'b0;
      data_q   <= '0;
      len_q    <= '0;
      cdiv_q   <= '0;
      cpha_q   <= 1'b0;
      lsb_q    <= 1'b0;
      cs_val_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sdo_q    <= 1'b0;
      sck_q    <= 1'b0;
      cs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      ph_q     <= ph_d;
      cs_val_q <= cs_val_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sdo_q    <= sdo_d;
      sck_q    <= sck_d;
      cs_q     <= cs_d;
      if (accept) begin
        data_q <= bus.data_in;
        len_q  <= len_in;
        cdiv_q <= bus.clk_div;
        cpha_q <= bus.cpha;
        lsb_q  <= bus.lsb_first;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q + 1'b1;
    bit_d   = bit_q;
    ph_d    = ph_q;
    unique case (state_q)
      S_IDLE: begin
        div_d = '0;
        if (accept) state_d = S_SETUP;
      end
      S_SETUP: if (div_last) begin
        state_d = S_SHIFT;
        div_d   = '0;
        bit_d   = '0;
        ph_d    = 1'b0;
      end
      S_SHIFT: if (div_last) begin
        div_d = '0;
        ph_d  = ~ph_q;
        if (ph_q) begin
          if (bit_q == len_q - 1'b1) state_d = S_HOLD;
          else bit_d = bit_q + 1'b1;
        end
      end
      S_HOLD: if (div_last) begin
        state_d = S_GAP;
        div_d   = '0;
      end
      S_GAP: if (div_last) begin
        state_d = S_DONE;
        div_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        div_d   = '0;
      end
    endcase
  end

  // Outputs are derived from next-state so the registers line up with state_q.
  always_comb begin
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    cs_d     = state_d inside {S_SETUP, S_SHIFT, S_HOLD};
    sck_d    = (state_d == S_SHIFT) && (ph_d ^ cpha_q);
    cs_val_d = accept ? bus.cs_sel : cs_val_q;
    sdo_d    = sdo_q;
    unique case (state_d)
      S_SETUP: if (state_q == S_IDLE)
        sdo_d = pick(bus.data_in, len_in, bus.lsb_first, '0);
      S_SHIFT: if (!ph_d && div_d == '0)
        sdo_d = pick(data_q, len_q, lsb_q, bit_d);
      S_HOLD: sdo_d = sdo_q;
      default: sdo_d = 1'b0;
    endcase
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sdo      = sdo_q;
  assign bus.sck_next = sck_q;
  assign bus.cs_next  = cs_q;
  assign bus.cs_val   = cs_val_q;

`ifdef SPI_READBACK_EN
  logic [LEN_WIDTH-1:0]  rb_q;
  logic                  sen_q, sen_d;
  logic [DATA_WIDTH-1:0] cap_q, cap_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  smp;

  assign smp = sen_q && (state_q == S_SHIFT) && ph_q && div_last;

  always_comb begin
    sen_d = (rb_q < len_q)
            && (((state_d == S_SHIFT) && (bit_d >= rb_q))
                || (state_d == S_HOLD));
    cap_d = cap_q;
    if (accept) cap_d = '0;
    else if (smp) cap_d = {cap_q[DATA_WIDTH-2:0], bus.sdi_in};
    dout_d = (state_d == S_DONE) ? cap_q : dout_q;
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      rb_q   <= '0;
      sen_q  <= 1'b0;
      cap_q  <= '0;
      dout_q <= '0;
    end else begin
      if (accept) rb_q <= bus.readback_start;
      sen_q  <= sen_d;
      cap_q  <= cap_d;
      dout_q <= dout_d;
    end
  end

  assign bus.slave_en = sen_q;
  assign bus.data_out = dout_q;
`else
  logic unused_rb;
  assign unused_rb    = ^{bus.readback_start, bus.sdi_in};
  assign bus.slave_en = 1'b0;
  assign bus.data_out = '0;
`endif

endmodule

// File: tb/tb_spi_master_engine.sv
// Self-checking bench for spi_master_engine against a
// cycle-count reference model of the transfer waveform.
module tb_spi_master_engine;
  localparam int DW = 64;
  localparam int LW = 7;
  localparam int VW = 8;
  localparam int NC = 1;
`ifdef SPI_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  spi_master_engine_if #(
    .DATA_WIDTH(DW), .LEN_WIDTH(LW),
    .DIV_WIDTH(VW), .NUM_CS(NC)
  ) bus ();

  spi_master_engine #(
    .DATA_WIDTH(DW), .LEN_WIDTH(LW),
    .DIV_WIDTH(VW), .NUM_CS(NC)
  ) dut (
    .CLK100MHZ(clk),
    .reset(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({bus.busy, bus.done, bus.cs_next, bus.sck_next,
                bus.sdo, bus.slave_en, bus.cs_val,
                (bus.data_out != '0)});
  endfunction

  // Runs one transfer and checks every cycle from the first busy cycle
  // to one cycle past done against timing derived from L and H.
  task automatic run_xfer(input string tag,
                          input logic [63:0] d, input int len,
                          input int dv, input bit cph, input bit lsb,
                          input logic cs, input int rb,
                          input logic [63:0] sw, input bit poke);
    int L, H, Tcs, Tdone, s, b;
    logic [63:0] exp_do;
    logic [5:0] ex;
    logic bitv, sen;
    L = (len > DW) ? DW : len;
    H = dv + 1;
    Tcs = (2 * L + 2) * H;
    Tdone = Tcs + H;
    exp_do = '0;
    if (RB && rb < L)
      for (int i = rb; i < L; i++)
        exp_do = {exp_do[62:0], sw[L-1-i]};

    @(negedge clk);
    bus.data_in        = d;
    bus.length         = LW'(len);
    bus.clk_div        = VW'(dv);
    bus.cpha           = cph;
    bus.lsb_first      = lsb;
    bus.cs_sel         = cs;
    bus.readback_start = LW'(rb);
    bus.sdi_in         = 1'b0;
    bus.start          = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 0; c <= Tdone + 1; c++) begin
      if (c > 0) @(negedge clk);
      s = c - H;
      b = (s >= 0 && s < 2 * L * H) ? s / (2 * H) : -1;
      if (c < H) bitv = lsb ? d[0] : d[L-1];
      else if (b >= 0) bitv = lsb ? d[b] : d[L-1-b];
      else if (c >= Tcs - H && c < Tcs) bitv = lsb ? d[L-1] : d[0];
      else bitv = 1'b0;
      sen = RB && (rb < L)
            && ((b >= rb) || (c >= Tcs - H && c < Tcs));
      ex[5] = (c <= Tdone);
      ex[4] = (c == Tdone);
      ex[3] = (c < Tcs);
      ex[2] = (b >= 0) ? (((s / H) % 2 == 0) ? cph : !cph) : 1'b0;
      ex[1] = bitv;
      ex[0] = sen;
      check($sformatf("%s c%0d bsy/dn/cs/sck/sdo/sen", tag, c),
            64'({bus.busy, bus.done, bus.cs_next, bus.sck_next,
                 bus.sdo, bus.slave_en}),
            64'(ex));
      if (c == 0 || c == Tdone)
        check($sformatf("%s c%0d cs_val", tag, c),
              64'(bus.cs_val), 64'(cs));
      if (c >= Tdone)
        check($sformatf("%s c%0d data_out", tag, c),
              bus.data_out, exp_do);
      if (poke && c == 2) begin
        bus.start     = 1'b1;
        bus.data_in   = ~d;
        bus.cs_sel    = ~cs;
        bus.length    = LW'(8);
        bus.lsb_first = ~lsb;
      end
      if (poke && c == 3) bus.start = 1'b0;
      bus.sdi_in = (b >= 0 && b < L) ? sw[L-1-b] : 1'b0;
    end
  endtask

  initial begin
    logic [63:0] rd, rs;
    int rl, rdv, rrb;
    rst                = 1'b1;
    bus.start          = 1'b0;
    bus.data_in        = '0;
    bus.length         = '0;
    bus.clk_div        = '0;
    bus.cpha           = 1'b0;
    bus.lsb_first      = 1'b0;
    bus.cs_sel         = '0;
    bus.readback_start = '0;
    bus.sdi_in         = 1'b0;
    repeat (3) @(negedge clk);
    check("reset outputs", all_outs(), 64'(0));
    rst = 1'b0;

    run_xfer("a5_msb", 64'hA5, 8, 0, 1'b0, 1'b0, 1'b1, 99, '0, 1'b0);
    run_xfer("6_lsb_cpha", 64'h6, 4, 3, 1'b1, 1'b1, 1'b1, 99, '0, 1'b0);

    @(negedge clk);
    bus.length = '0;
    bus.start  = 1'b1;
    @(negedge clk);
    check("len0 busy", 64'(bus.busy), 64'(0));
    bus.start = 1'b0;
    @(negedge clk);
    check("len0 idle", 64'({bus.busy, bus.cs_next}), 64'(0));

    run_xfer("poke_busy", 64'h3C5A, 16, 1, 1'b0, 1'b0, 1'b1, 99, '0, 1'b1);
    run_xfer("clamp80", {$urandom, $urandom}, 80, 0, 1'b0, 1'b0,
             1'b1, 99, '0, 1'b0);
    run_xfer("readback", 64'hBEEF, 16, 0, 1'b0, 1'b0, 1'b1, 8,
             64'h3C, 1'b0);
    run_xfer("divmax", 64'h1, 1, 255, 1'b1, 1'b0, 1'b0, 0,
             64'h1, 1'b0);

    // Abort mid-transfer at bit 3 and confirm a clean return to idle.
    @(negedge clk);
    bus.data_in        = 64'hA5;
    bus.length         = LW'(8);
    bus.clk_div        = '0;
    bus.cpha           = 1'b0;
    bus.lsb_first      = 1'b0;
    bus.cs_sel         = 1'b1;
    bus.readback_start = LW'(0);
    bus.start          = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    check("pre-abort cs", 64'(bus.cs_next), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    check("abort outputs", all_outs(), 64'(0));
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("abort quiet %0d", i),
            64'({bus.busy, bus.done, bus.cs_next}), 64'(0));
    end
    run_xfer("after_abort", 64'hA5, 8, 0, 1'b0, 1'b0, 1'b1, 4,
             64'hF0, 1'b0);

    for (int n = 0; n < 10; n++) begin
      rd  = {$urandom, $urandom};
      rs  = {$urandom, $urandom};
      rl  = $urandom_range(1, 70);
      rdv = $urandom_range(0, 3);
      rrb = $urandom_range(0, rl + 2);
      run_xfer($sformatf("rand%0d", n), rd, rl, rdv,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), rrb, rs, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
